// File: rtl/parity_serial_tx_if.sv
// Upstream word handshake and serial-line status bundle for parity_serial_tx.
// master: the upstream parity generator; slave: the serialiser.
// in_valid/in_ready is a plain valid-ready handshake; tx_out/busy/frame_done are status.
interface parity_serial_tx_if #(
   parameter int DATA_W = 3
) ();
   logic [DATA_W-1:0] data_in;
   logic              parity_in;
   logic              in_valid;
   logic              in_ready;
   logic              tx_out;
   logic              busy;
   logic              frame_done;

   modport master (
      output data_in, parity_in, in_valid,
      input  in_ready, tx_out, busy, frame_done
   );

   modport slave (
      input  data_in, parity_in, in_valid,
      output in_ready, tx_out, busy, frame_done
   );
endinterface

// File: rtl/parity_serial_tx.sv
// Serialises a data word plus its upstream parity bit as start/data(LSB first)/parity/stop.
// Latency: start bit appears the cycle after accept; frame is (DATA_W+3)*CLKS_PER_BIT cycles.
// Backpressure: in_ready only in IDLE, so at least one idle cycle separates frames.
module parity_serial_tx #(
   parameter int DATA_W       = 3,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   parity_serial_tx_if.slave   bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [IDX_W-1:0]  bit_idx;
   logic [IDX_W-1:0]  bit_idx_nxt;
   logic [DATA_W-1:0] data_q;
   logic              parity_q;
   logic              accept;
   logic              bit_end;

   assign bit_end = (cnt == CNT_LAST);
   assign accept  = (state == IDLE) && bus.in_valid;

   // State, counters and the captured word; the word is frozen for the whole frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         if (accept) begin
            data_q   <= bus.data_in;
            parity_q <= bus.parity_in;
         end
      end
   end

   // Next-state: every bit lasts CLKS_PER_BIT cycles; the cycle counter restarts on each move.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
            if (bus.in_valid) begin
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               // Index saturates at the last data bit; PARITY takes over from there.
               if (bit_idx == IDX_LAST) begin
                  state_nxt = PARITY;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
         end
      endcase
   end

   // Line level decoded from state; idle and stop both hold the line high.
   always_comb begin
      bus.tx_out = 1'b1;
      case (state)
         START:   bus.tx_out = 1'b0;
         DATA:    bus.tx_out = data_q[bit_idx];
         PARITY:  bus.tx_out = parity_q;
         default: bus.tx_out = 1'b1;
      endcase
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed-plus-random bench for parity_serial_tx against a frame-level reference model.
// Expected line levels come from the frame format (start, data LSB first, parity, stop).
// A receiver-style decoder re-reads each frame from mid-bit samples.
module tb_parity_serial_tx;

   localparam int DW    = 3;
   localparam int CPB   = 4;
   localparam int FRAME = (DW + 3) * CPB;

   logic clk;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   done_cnt    = 0;
   int   frames_sent = 0;

   parity_serial_tx_if #(.DATA_W(DW)) bus ();

   parity_serial_tx #(
      .DATA_W       (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle count used to measure frame spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Tally of frame_done pulses, compared with frames completed at the end.
   always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"},    bus.tx_out,     1);
      check({tag, "_rdy"},   bus.in_ready,   1);
      check({tag, "_busy"},  bus.busy,       0);
      check({tag, "_done"},  bus.frame_done, 0);
   endtask

   // Waits (bounded) for in_ready, then presents the word for acceptance.
   task automatic start_frame(input logic [DW-1:0] d, input logic p);
      for (int n = 0; n < 100 && bus.in_ready !== 1'b1; n++) @(negedge clk);
      check("ready_wait", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.data_in   = d;
      bus.parity_in = p;
   endtask

   // Follows one frame from its first start-bit cycle to the idle cycle after it.
   task automatic check_frame(input logic [DW-1:0] d, input logic p,
                              input logic nv, input logic [DW-1:0] nd, input logic np,
                              input bit fixed_junk, input bit check_even,
                              output int start_cyc);
      logic       exp_q[$];
      logic       rx[DW+3];
      logic [DW-1:0] rx_d;
      int         ones;
      exp_q.push_back(1'b0);
      for (int k = 0; k < DW; k++) exp_q.push_back(d[k]);
      exp_q.push_back(p);
      exp_q.push_back(1'b1);
      @(negedge clk);
      start_cyc = cyc;
      for (int i = 0; i < FRAME; i++) begin
         check("tx_out",     bus.tx_out,     exp_q[i / CPB]);
         check("busy",       bus.busy,       1);
         check("in_ready",   bus.in_ready,   0);
         check("frame_done", bus.frame_done, (i == FRAME - 1));
         if (i % CPB == CPB / 2) rx[i / CPB] = bus.tx_out;
         if (i < FRAME - 1) begin
            if (fixed_junk) begin
               bus.in_valid  = 1'b1;
               bus.data_in   = '1;
               bus.parity_in = 1'b1;
            end else begin
               bus.in_valid  = 1'($urandom);
               bus.data_in   = DW'($urandom);
               bus.parity_in = 1'($urandom);
            end
         end else begin
            bus.in_valid  = nv;
            bus.data_in   = nd;
            bus.parity_in = np;
         end
         @(negedge clk);
      end
      check_idle("gap");
      rx_d = '0;
      for (int k = 0; k < DW; k++) rx_d[k] = rx[k + 1];
      check("rx_start",  rx[0],      0);
      check("rx_data",   rx_d,       d);
      check("rx_parity", rx[DW + 1], p);
      check("rx_stop",   rx[DW + 2], 1);
      if (check_even) begin
         ones = 0;
         for (int k = 1; k <= DW + 1; k++) ones += int'(rx[k]);
         check("even_ones", ones % 2, 0);
      end
      frames_sent++;
   endtask

   initial begin
      int s1, s2, s3;
      logic [DW-1:0] rd;
      logic          rp;

      // Reset with a valid word present: it must not be taken.
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.data_in   = 3'b111;
      bus.parity_in = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("rst");
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;

      // Quiet line for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("quiet");
      end

      // Basic frame 101 / parity 0.
      start_frame(3'b101, 1'b0);
      check_frame(3'b101, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, s1);

      // Back-to-back words with in_valid held high.
      @(negedge clk);
      start_frame(3'b110, 1'b0);
      check_frame(3'b110, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, s1);
      check_frame(3'b011, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, s2);
      check("b2b_period", s2 - s1, FRAME + 1);

      // A word offered during the frame is taken only at the next idle.
      @(negedge clk);
      start_frame(3'b001, 1'b1);
      check_frame(3'b001, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, s1);
      check_frame(3'b111, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, s3);
      check("held_word_period", s3 - s1, FRAME + 1);

      // Reset during the parity bit aborts the frame with no completion.
      @(negedge clk);
      start_frame(3'b010, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat ((1 + DW) * CPB + 1) @(negedge clk);
      check("abort_parity_bit", bus.tx_out, 1);
      check("abort_busy_pre",   bus.busy,   1);
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_idle("abort");
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("post_abort");
      end

      // All 8 words with even parity, decoded from the line.
      for (int v = 0; v < 8; v++) begin
         rd = DW'(v);
         rp = ^rd;
         start_frame(rd, rp);
         check_frame(rd, rp, 1'b0, '0, 1'b0, 1'b0, 1'b1, s1);
      end

      // Random words and parities with random traffic during frames.
      for (int n = 0; n < 10; n++) begin
         rd = DW'($urandom);
         rp = 1'($urandom);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         start_frame(rd, rp);
         check_frame(rd, rp, 1'b0, '0, 1'b0, 1'b0, 1'b0, s1);
      end

      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt, frames_sent);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
